// File: rtl/touch_filt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : touch_filt_pkg
//  Purpose  : Shared types, defaults and helpers for the touch coordinate
//             filter (FSM state, panel defaults, sum width, |a-b|).
//  Revision : 1.0 - initial release
// ============================================================================
package touch_filt_pkg;

  // Filter tracking state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TRACK = 2'd2
  } filt_state_e;

  localparam int unsigned COORD_W   = 16;
  localparam int unsigned DEF_H_RES = 800;
  localparam int unsigned DEF_V_RES = 480;

  // Running-sum width: a full window of 16-bit samples never overflows it
  function automatic int unsigned sum_width(input int unsigned avg_log2);
    return COORD_W + avg_log2;
  endfunction

  // Unsigned absolute difference of two coordinates
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/touch_coord_filter_avg_win.sv
`default_nettype none
// ============================================================================
//  Module   : touch_avg_win
//  Purpose  : One axis of the moving-average filter: circular sample window,
//             running sum (sum += new - oldest) and truncated mean.
//  Revision : 1.0 - initial release
// ============================================================================
module touch_avg_win
  import touch_filt_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PTR_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   ptr,
  input  logic [COORD_W-1:0] din,
  output logic [COORD_W-1:0] mean
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = sum_width(AVG_LOG2);

  logic [COORD_W-1:0] win_q [DEPTH];
  logic [COORD_W-1:0] win_d [DEPTH];
  logic [SUM_W-1:0]   sum_q;
  logic [SUM_W-1:0]   sum_d;
  logic [COORD_W-1:0] oldest;

  // Replace the slot under the pointer and adjust the running sum by the delta
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == PTR_W'(i)) oldest = win_q[i];
    end
    win_d = win_q;
    sum_d = sum_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
      sum_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr == PTR_W'(i)) win_d[i] = din;
      end
      sum_d = sum_q + SUM_W'(din) - SUM_W'(oldest);
    end
  end

  // Window and sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q <= '0;
    end else begin
      win_q <= win_d;
      sum_q <= sum_d;
    end
  end

  // Truncating divide by the window depth
  assign mean = sum_q[AVG_LOG2 +: COORD_W];

endmodule
`default_nettype wire

// File: rtl/touch_coord_filter.sv
`default_nettype none
// ============================================================================
//  Module   : touch_coord_filter
//  Purpose  : Clamp, average and de-jitter raw touch samples; generate
//             pen-down / pen-up strobes with a release timeout. Output is a
//             FIFO write stream, fixed 3-cycle latency from touch_data_flag.
//  Options  : TOUCH_FILT_MIRROR_EN - mirror both axes (panel rotated 180 deg)
//  Revision : 1.0 - initial release
// ============================================================================
module touch_coord_filter
  import touch_filt_pkg::*;
#(
  parameter int unsigned H_RES       = DEF_H_RES,
  parameter int unsigned V_RES       = DEF_V_RES,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned MOVE_THRESH = 2,
  parameter logic [15:0] CNT_MS_MAX  = 16'd49_999,
  parameter int unsigned RELEASE_MS  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] touch_x_loc,
  input  logic [15:0] touch_y_loc,
  input  logic        touch_data_flag,
  output logic [15:0] filt_x,
  output logic [15:0] filt_y,
  output logic        filt_valid,
  output logic        pen_down,
  output logic        pen_up,
  output logic        pen_active
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] THRESH   = COORD_W'(MOVE_THRESH);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [15:0]        MS_LAST  = 16'(RELEASE_MS - 1);

  // Stage A
  logic               a_valid_q, a_valid_d;
  logic [COORD_W-1:0] a_x_q, a_x_d, a_y_q, a_y_d;
  logic [COORD_W-1:0] x_clamp, y_clamp;
  // Stage B
  logic               b_valid_q, b_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COORD_W-1:0] mean_x, mean_y;
  // Release timer
  logic [15:0]        presc_q, presc_d, presc_base;
  logic [15:0]        ms_q, ms_d, ms_base;
  logic               expire;
  // Stage C / FSM
  filt_state_e        state_q, state_d;
  logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic [COORD_W-1:0] filt_x_q, filt_x_d, filt_y_q, filt_y_d;
  logic               filt_valid_q, filt_valid_d;
  logic               pen_down_q, pen_down_d;
  logic               pen_up_q, pen_up_d;
  logic [COORD_W-1:0] dx, dy;
  logic               moved;

  // Stage A: clamp to the panel (optionally mirror) and capture with the strobe
  always_comb begin
    x_clamp   = (touch_x_loc > X_MAX) ? X_MAX : touch_x_loc;
    y_clamp   = (touch_y_loc > Y_MAX) ? Y_MAX : touch_y_loc;
    a_valid_d = touch_data_flag;
    a_x_d     = a_x_q;
    a_y_d     = a_y_q;
    if (touch_data_flag) begin
`ifdef TOUCH_FILT_MIRROR_EN
      a_x_d = X_MAX - x_clamp;
      a_y_d = Y_MAX - y_clamp;
`else
      a_x_d = x_clamp;
      a_y_d = y_clamp;
`endif
    end
  end

  // Stage A registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_x_q     <= '0;
      a_y_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_x_q     <= a_x_d;
      a_y_q     <= a_y_d;
    end
  end

  // Stage B control: shared write pointer and saturating fill count
  always_comb begin
    b_valid_d = a_valid_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    if (expire) begin
      b_valid_d = 1'b0;
      cnt_d     = '0;
      ptr_d     = '0;
    end else if (a_valid_q) begin
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Stage B control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  touch_avg_win #(
    .AVG_LOG2 (AVG_LOG2),
    .PTR_W    (PTR_W)
  ) u_win_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (expire),
    .wr_en (a_valid_q),
    .ptr   (ptr_q),
    .din   (a_x_q),
    .mean  (mean_x)
  );

  touch_avg_win #(
    .AVG_LOG2 (AVG_LOG2),
    .PTR_W    (PTR_W)
  ) u_win_y (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (expire),
    .wr_en (a_valid_q),
    .ptr   (ptr_q),
    .din   (a_y_q),
    .mean  (mean_y)
  );

  // Release timer: the a_valid cycle counts as tick 0, so expiry is detected
  // one cycle ahead and the registered pen_up lands exactly on the deadline.
  // A sample in the expiry cycle wins and restarts the count.
  always_comb begin
    expire     = (state_q != ST_IDLE) && !a_valid_q &&
                 (ms_q == MS_LAST) && (presc_q == CNT_MS_MAX);
    presc_base = a_valid_q ? 16'd0 : presc_q;
    ms_base    = a_valid_q ? 16'd0 : ms_q;
    if (expire || ((state_q == ST_IDLE) && !a_valid_q)) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (presc_base == CNT_MS_MAX) begin
      presc_d = '0;
      ms_d    = ms_base + 16'd1;
    end else begin
      presc_d = presc_base + 16'd1;
      ms_d    = ms_base;
    end
  end

  // Release timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  assign dx    = abs_diff(mean_x, last_x_q);
  assign dy    = abs_diff(mean_y, last_y_q);
  assign moved = (dx > THRESH) || (dy > THRESH);

  // Stage C: stroke FSM and emission decision
  always_comb begin
    state_d      = state_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    filt_x_d     = filt_x_q;
    filt_y_d     = filt_y_q;
    filt_valid_d = 1'b0;
    pen_down_d   = 1'b0;
    pen_up_d     = 1'b0;
    if (expire) begin
      state_d  = ST_IDLE;
      pen_up_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (a_valid_q) state_d = ST_FILL;
        end
        ST_FILL: begin
          if (b_valid_q && (cnt_q == CNT_FULL)) begin
            state_d      = ST_TRACK;
            filt_valid_d = 1'b1;
            pen_down_d   = 1'b1;
            filt_x_d     = mean_x;
            filt_y_d     = mean_y;
            last_x_d     = mean_x;
            last_y_d     = mean_y;
          end
        end
        ST_TRACK: begin
          if (b_valid_q && moved) begin
            filt_valid_d = 1'b1;
            filt_x_d     = mean_x;
            filt_y_d     = mean_y;
            last_x_d     = mean_x;
            last_y_d     = mean_y;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Stage C / FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_x_q     <= '0;
      last_y_q     <= '0;
      filt_x_q     <= '0;
      filt_y_q     <= '0;
      filt_valid_q <= 1'b0;
      pen_down_q   <= 1'b0;
      pen_up_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      filt_x_q     <= filt_x_d;
      filt_y_q     <= filt_y_d;
      filt_valid_q <= filt_valid_d;
      pen_down_q   <= pen_down_d;
      pen_up_q     <= pen_up_d;
    end
  end

  assign filt_x     = filt_x_q;
  assign filt_y     = filt_y_q;
  assign filt_valid = filt_valid_q;
  assign pen_down   = pen_down_q;
  assign pen_up     = pen_up_q;
  // Active from the first captured sample of a stroke until pen-up
  assign pen_active = (state_q != ST_IDLE) || a_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_coord_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_touch_coord_filter
//  Purpose  : Directed self-checking bench for touch_coord_filter
//             (AVG_LOG2=2, MOVE_THRESH=2, CNT_MS_MAX=9, RELEASE_MS=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_touch_coord_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx = '0;
  logic [15:0] ty = '0;
  logic        flag = 1'b0;
  logic [15:0] fx, fy;
  logic        fv, pd, pu, pa;

  int checks = 0;
  int errors = 0;

  // Expected filtered points (unmirrored / mirrored panel)
`ifdef TOUCH_FILT_MIRROR_EN
  localparam logic [15:0] FILL_X = 16'd699, FILL_Y = 16'd279;
  localparam logic [15:0] CLMP_X = 16'd0,   CLMP_Y = 16'd0;
  localparam logic [15:0] RFIL_X = 16'd749, RFIL_Y = 16'd419;
  logic [15:0] jit_x [4] = '{16'd693, 16'd688, 16'd683, 16'd679};
  logic [15:0] jit_y [4] = '{16'd278, 16'd278, 16'd278, 16'd279};
  logic [15:0] b2b_x [5] = '{16'd784, 16'd774, 16'd764, 16'd754, 16'd744};
`else
  localparam logic [15:0] FILL_X = 16'd100, FILL_Y = 16'd200;
  localparam logic [15:0] CLMP_X = 16'd799, CLMP_Y = 16'd479;
  localparam logic [15:0] RFIL_X = 16'd50,  RFIL_Y = 16'd60;
  logic [15:0] jit_x [4] = '{16'd105, 16'd110, 16'd115, 16'd120};
  logic [15:0] jit_y [4] = '{16'd200, 16'd200, 16'd200, 16'd200};
  logic [15:0] b2b_x [5] = '{16'd15, 16'd25, 16'd35, 16'd45, 16'd55};
`endif

  always #5 clk = ~clk;

  touch_coord_filter #(
    .H_RES       (800),
    .V_RES       (480),
    .AVG_LOG2    (2),
    .MOVE_THRESH (2),
    .CNT_MS_MAX  (16'd9),
    .RELEASE_MS  (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .touch_x_loc     (tx),
    .touch_y_loc     (ty),
    .touch_data_flag (flag),
    .filt_x          (fx),
    .filt_y          (fy),
    .filt_valid      (fv),
    .pen_down        (pd),
    .pen_up          (pu),
    .pen_active      (pa)
  );

  // Advance n clock edges; observe 1 ns after each edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle raw strobe; returns at the T+1 view
  task automatic strobe(input logic [15:0] x, input logic [15:0] y);
    tx = x; ty = y; flag = 1'b1;
    tick(1);
    flag = 1'b0;
  endtask

  // Four strobes of the same point: silent for three, pen_down on the fourth
  task automatic fill4(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ex, input logic [15:0] ey);
    for (int i = 0; i < 4; i++) begin
      strobe(x, y);
      if (i == 0) begin
        checks++;
        if (pa !== 1'b1) begin errors++; $display("FAIL %s_pen_active got %0b want 1", tag, pa); end
      end
      tick(2);
      checks++;
      if (i < 3) begin
        if ({fv, pd} !== 2'b00) begin
          errors++; $display("FAIL %s_early%0d got v%0b d%0b want v0 d0", tag, i, fv, pd);
        end
      end else begin
        if ({fv, pd, pu, fx, fy} !== {3'b110, ex, ey}) begin
          errors++;
          $display("FAIL %s_emit got v%0b d%0b u%0b x%0d y%0d want v1 d1 u0 x%0d y%0d",
                   tag, fv, pd, pu, fx, fy, ex, ey);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({fv, pd, pu, pa, fx, fy} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {fv, pd, pu, pa, fx, fy});
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if ({fv, pu, pa} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b want 000", {fv, pu, pa});
    end
  endtask

  task automatic test_fill();
    fill4("fill", 16'd100, 16'd200, FILL_X, FILL_Y);
    tick(1);
    checks++;
    if ({fv, pd} !== 2'b00) begin
      errors++; $display("FAIL fill_strobe_width got v%0b d%0b want v0 d0", fv, pd);
    end
  endtask

  task automatic test_jitter();
    strobe(16'd101, 16'd200);
    tick(2);
    checks++;
    if (fv !== 1'b0) begin errors++; $display("FAIL jitter_101 got v%0b want v0", fv); end
    strobe(16'd102, 16'd201);
    tick(2);
    checks++;
    if (fv !== 1'b0) begin errors++; $display("FAIL jitter_102 got v%0b want v0", fv); end
    for (int i = 0; i < 4; i++) begin
      strobe(16'd120, 16'd200);
      tick(2);
      checks++;
      if ({fv, pd, fx, fy} !== {2'b10, jit_x[i], jit_y[i]}) begin
        errors++;
        $display("FAIL jitter_move%0d got v%0b d%0b x%0d y%0d want v1 d0 x%0d y%0d",
                 i, fv, pd, fx, fy, jit_x[i], jit_y[i]);
      end
    end
  endtask

  // Entered at the T+3 view of the last strobe
  task automatic test_timeout();
    tick(27);
    checks++;
    if ({pu, pa} !== 2'b01) begin errors++; $display("FAIL timeout_early got u%0b a%0b want u0 a1", pu, pa); end
    tick(1);
    checks++;
    if ({fv, pu, pa} !== 3'b010) begin
      errors++; $display("FAIL timeout_pen_up got v%0b u%0b a%0b want v0 u1 a0", fv, pu, pa);
    end
    tick(1);
    checks++;
    if ({pu, pa} !== 2'b00) begin errors++; $display("FAIL timeout_after got u%0b a%0b want u0 a0", pu, pa); end
  endtask

  task automatic test_clamp_and_collision();
    fill4("clamp", 16'd900, 16'd600, CLMP_X, CLMP_Y);
    tick(26);
    strobe(16'd900, 16'd600);   // a_valid lands on the expiry cycle
    tick(1);
    checks++;
    if ({pu, pa} !== 2'b01) begin errors++; $display("FAIL collide_no_pen_up got u%0b a%0b want u0 a1", pu, pa); end
    tick(1);
    checks++;
    if ({fv, pu} !== 2'b00) begin errors++; $display("FAIL collide_no_emit got v%0b u%0b want v0 u0", fv, pu); end
    tick(27);
    checks++;
    if (pu !== 1'b0) begin errors++; $display("FAIL collide_reload_early got u%0b want u0", pu); end
    tick(1);
    checks++;
    if ({pu, pa} !== 2'b10) begin errors++; $display("FAIL collide_reload_pen_up got u%0b a%0b want u1 a0", pu, pa); end
  endtask

  task automatic test_back_to_back();
    int v;
    for (int n = 0; n < 11; n++) begin
      if (n < 8) begin tx = 16'(10 * n); ty = 16'd0; flag = 1'b1; end
      else flag = 1'b0;
      tick(1);
      v = n + 1;
      checks++;
      if (v >= 6 && v <= 10) begin
        if ({fv, pd, fx} !== {1'b1, (v == 6), b2b_x[v-6]}) begin
          errors++;
          $display("FAIL b2b_t%0d got v%0b d%0b x%0d want v1 d%0b x%0d", v, fv, pd, fx, (v == 6), b2b_x[v-6]);
        end
      end else if (fv !== 1'b0) begin
        errors++; $display("FAIL b2b_t%0d got v%0b want v0", v, fv);
      end
    end
    flag = 1'b0;
    tick(26);
    checks++;
    if ({pu, pa} !== 2'b01) begin errors++; $display("FAIL b2b_timeout_early got u%0b a%0b want u0 a1", pu, pa); end
    tick(1);
    checks++;
    if (pu !== 1'b1) begin errors++; $display("FAIL b2b_timeout got u%0b want u1", pu); end
  endtask

  task automatic test_reset_mid();
    tick(2);
    strobe(16'd50, 16'd60);
    strobe(16'd50, 16'd60);
    checks++;
    if (pa !== 1'b1) begin errors++; $display("FAIL midrst_active got a%0b want a1", pa); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fv, pd, pu, pa, fx, fy} !== 36'd0) begin
      errors++; $display("FAIL midrst_async got %h want 0", {fv, pd, pu, pa, fx, fy});
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({pu, pa} !== 2'b00) begin errors++; $display("FAIL midrst_no_pen_up got u%0b a%0b want u0 a0", pu, pa); end
    fill4("refill", 16'd50, 16'd60, RFIL_X, RFIL_Y);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_jitter();
    test_timeout();
    test_clamp_and_collision();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
